// File: rtl/uart_core.sv
// 8N1 full-duplex UART: shared 16x oversample tick, TX serializer and RX deserializer
// with a byte-wide handshake on each side.
module uart_core #(
    parameter int freq_hz = 50000000,
    parameter int baud    = 115200
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       uart_rxd,
    output logic       uart_txd,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       rx_error,
    input  logic       rx_ack,
    input  logic [7:0] tx_data,
    input  logic       tx_wr,
    output logic       tx_busy
);

    localparam int DIV_RAW = freq_hz / (baud * 16);
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int TW      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [TW-1:0] tick_cnt;
    logic          tick;

    assign tick = (tick_cnt == TICK_LAST);

    // NOTE: state registers use non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + TW'(1);
    end

    // ---------------- transmitter ----------------
    logic [1:0] tx_state;
    logic [3:0] tx_cnt;
    logic [2:0] tx_bit;
    logic [7:0] tx_shift;
    logic       tx_go;      // start bit already on the line

    assign tx_busy = (tx_state != S_IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx_shift <= '0;
            tx_go    <= 1'b0;
            uart_txd <= 1'b1;
        end else begin
            case (tx_state)
                S_IDLE: if (tx_wr) begin
                    tx_shift <= tx_data;
                    tx_go    <= 1'b0;
                    tx_state <= S_START;
                end
                S_START: if (tick) begin
                    // first tick only drops the line; the 16-tick bit time starts here
                    if (!tx_go) begin
                        tx_go    <= 1'b1;
                        uart_txd <= 1'b0;
                        tx_cnt   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt + 4'd1;
                        if (tx_cnt == 4'd15) begin
                            uart_txd <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= '0;
                            tx_state <= S_DATA;
                        end
                    end
                end
                S_DATA: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == 4'd15) begin
                        if (tx_bit == 3'd7) begin
                            uart_txd <= 1'b1;
                            tx_state <= S_STOP;
                        end else begin
                            uart_txd <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit + 3'd1;
                        end
                    end
                end
                S_STOP: if (tick) begin
                    tx_cnt <= tx_cnt + 4'd1;
                    if (tx_cnt == 4'd15) tx_state <= S_IDLE;
                end
                default: tx_state <= S_IDLE;
            endcase
        end
    end

    // ---------------- receiver ----------------
    logic [1:0] rxd_sync;
    logic       rxd_s;
    logic [1:0] rx_state;
    logic [3:0] rx_cnt;
    logic [2:0] rx_bit;
    logic [7:0] rx_shift;
    logic       rx_armed;   // line seen idle-high since the last frame

    assign rxd_s = rxd_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) rxd_sync <= 2'b11;
        else       rxd_sync <= {rxd_sync[0], uart_rxd};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_armed <= 1'b0;
            rx_data  <= '0;
            rx_avail <= 1'b0;
            rx_error <= 1'b0;
        end else begin
            // a completion later in this block overrides the ack clear
            if (rx_ack) begin
                rx_avail <= 1'b0;
                rx_error <= 1'b0;
            end
            case (rx_state)
                S_IDLE: begin
                    if (!rx_armed) begin
                        rx_armed <= rxd_s;
                    end else if (!rxd_s) begin
                        rx_cnt   <= '0;
                        rx_state <= S_START;
                    end
                end
                S_START: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd7) begin
                        if (rxd_s) begin
                            rx_state <= S_IDLE;
                        end else begin
                            rx_cnt   <= '0;
                            rx_bit   <= '0;
                            rx_state <= S_DATA;
                        end
                    end
                end
                S_DATA: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15) begin
                        rx_shift <= {rxd_s, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                    end
                end
                S_STOP: if (tick) begin
                    rx_cnt <= rx_cnt + 4'd1;
                    if (rx_cnt == 4'd15) begin
                        if (rxd_s) begin
                            rx_data  <= rx_shift;
                            rx_avail <= 1'b1;
                        end else begin
                            rx_error <= 1'b1;
                        end
                        rx_armed <= 1'b0;
                        rx_state <= S_IDLE;
                    end
                end
                default: rx_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_core.sv
// Self-checking bench for uart_core: line-level frame model, loopback scoreboard,
// framing error, glitch rejection, busy-write drop and reset mid-frame.
module tb_uart_core;

    localparam int FREQ    = 50000000;
    localparam int BAUD    = 115200;
    localparam int DIV     = 27;
    localparam int BIT_CLK = DIV * 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       uart_rxd;
    logic       uart_txd;
    logic [7:0] rx_data;
    logic       rx_avail;
    logic       rx_error;
    logic       rx_ack = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_wr = 1'b0;
    logic       tx_busy;

    logic       loopback = 1'b0;
    logic       rxd_drv = 1'b1;
    logic [7:0] last_rx = 8'h00;

    int checks = 0;
    int failures = 0;

    assign uart_rxd = loopback ? uart_txd : rxd_drv;

    always #5 clk = ~clk;

    uart_core #(.freq_hz(FREQ), .baud(BAUD)) dut (
        .clk      (clk),
        .reset    (reset),
        .uart_rxd (uart_rxd),
        .uart_txd (uart_txd),
        .rx_data  (rx_data),
        .rx_avail (rx_avail),
        .rx_error (rx_error),
        .rx_ack   (rx_ack),
        .tx_data  (tx_data),
        .tx_wr    (tx_wr),
        .tx_busy  (tx_busy)
    );

    // Line image of one 8N1 frame, index 0 = start bit, 9 = stop bit.
    function automatic logic [9:0] frame_bits(input logic [7:0] b, input logic stop);
        return {stop, b, 1'b0};
    endfunction

    task automatic write_byte(input logic [7:0] b);
        @(posedge clk); #1;
        tx_data = b;
        tx_wr   = 1'b1;
        @(posedge clk); #1;
        tx_wr   = 1'b0;
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1;
        rx_ack = 1'b1;
        @(posedge clk); #1;
        rx_ack = 1'b0;
    endtask

    // Samples txd early and late inside each bit cell, relative to the first low sample.
    task automatic capture_tx_frame(output logic [9:0] early, output logic [9:0] late,
                                    output bit found);
        int off;
        early = '0;
        late  = '0;
        found = 1'b0;
        for (int n = 0; n < 4 * DIV; n++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) return;
        off = 0;
        for (int i = 0; i < 10; i++) begin
            repeat (i * BIT_CLK + 2 - off) @(negedge clk);
            early[i] = uart_txd;
            off = i * BIT_CLK + 2;
            repeat (i * BIT_CLK + BIT_CLK - 3 - off) @(negedge clk);
            late[i] = uart_txd;
            off = i * BIT_CLK + BIT_CLK - 3;
        end
    endtask

    task automatic count_busy(output int cycles);
        cycles = 0;
        while (cycles < 8000) begin
            @(negedge clk);
            if (tx_busy !== 1'b1) break;
            cycles++;
        end
    endtask

    task automatic wait_avail(input int limit, output int cycles, output bit seen);
        cycles = 0;
        seen = 1'b0;
        while (cycles < limit) begin
            @(negedge clk);
            cycles++;
            if (rx_avail === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(output bit idle);
        idle = 1'b0;
        for (int n = 0; n < 6000; n++) begin
            @(negedge clk);
            if (tx_busy === 1'b0) begin
                idle = 1'b1;
                break;
            end
        end
    endtask

    task automatic drive_frame(input logic [9:0] bits);
        for (int i = 0; i < 10; i++) begin
            rxd_drv = bits[i];
            repeat (BIT_CLK) @(posedge clk);
            #1;
        end
        rxd_drv = 1'b1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (uart_txd !== 1'b1) begin failures++; $display("FAIL reset_txd: got %b want 1", uart_txd); end
        checks++; if (tx_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", tx_busy); end
        checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL reset_avail: got %b want 0", rx_avail); end
        checks++; if (rx_error !== 1'b0) begin failures++; $display("FAIL reset_error: got %b want 0", rx_error); end
        checks++; if (rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        checks++; if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            failures++; $display("FAIL idle_after_reset: txd=%b busy=%b want 1/0", uart_txd, tx_busy);
        end
    endtask

    task automatic test_tx_frame();
        logic [9:0] early, late, exp;
        bit         found;
        int         busy_cycles;
        loopback = 1'b0;
        exp = frame_bits(8'h67, 1'b1);
        write_byte(8'h67);
        checks++; if (tx_busy !== 1'b1 || uart_txd !== 1'b1) begin
            failures++; $display("FAIL tx_accept: busy=%b txd=%b want 1/1", tx_busy, uart_txd);
        end
        fork
            capture_tx_frame(early, late, found);
            count_busy(busy_cycles);
        join
        checks++; if (!found) begin failures++; $display("FAIL tx_start_timeout: got no start bit want start within %0d clk", 4 * DIV); end
        checks++; if (early !== exp) begin failures++; $display("FAIL tx_bits_early: got %b want %b", early, exp); end
        checks++; if (late !== exp) begin failures++; $display("FAIL tx_bits_late: got %b want %b", late, exp); end
        checks++; if (busy_cycles < 10 * BIT_CLK || busy_cycles > 10 * BIT_CLK + DIV + 1) begin
            failures++; $display("FAIL tx_busy_len: got %0d want %0d..%0d", busy_cycles, 10 * BIT_CLK, 10 * BIT_CLK + DIV + 1);
        end
        checks++; if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            failures++; $display("FAIL tx_end_idle: txd=%b busy=%b want 1/0", uart_txd, tx_busy);
        end
    endtask

    task automatic test_loopback(input logic [7:0] b);
        int cycles;
        bit seen, idle;
        loopback = 1'b1;
        write_byte(b);
        wait_avail(6000, cycles, seen);
        checks++; if (!seen) begin failures++; $display("FAIL lb_avail_timeout: byte %h never arrived", b); end
        checks++; if (cycles < 9 * BIT_CLK + BIT_CLK / 2 || cycles > 9 * BIT_CLK + BIT_CLK / 2 + DIV + 4) begin
            failures++; $display("FAIL lb_latency: got %0d clk want %0d..%0d", cycles,
                                 9 * BIT_CLK + BIT_CLK / 2, 9 * BIT_CLK + BIT_CLK / 2 + DIV + 4);
        end
        checks++; if (rx_data !== b) begin failures++; $display("FAIL lb_data: got %h want %h", rx_data, b); end
        checks++; if (rx_error !== 1'b0) begin failures++; $display("FAIL lb_error: got %b want 0", rx_error); end
        last_rx = b;
        pulse_ack();
        checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL lb_ack_clear: got %b want 0", rx_avail); end
        wait_idle(idle);
        checks++; if (!idle) begin failures++; $display("FAIL lb_tx_idle_timeout: tx_busy stuck high"); end
    endtask

    task automatic test_framing_error();
        loopback = 1'b0;
        drive_frame(frame_bits(8'h55, 1'b0));
        repeat (4) @(negedge clk);
        checks++; if (rx_error !== 1'b1) begin failures++; $display("FAIL fe_error: got %b want 1", rx_error); end
        checks++; if (rx_avail !== 1'b0) begin failures++; $display("FAIL fe_avail: got %b want 0", rx_avail); end
        checks++; if (rx_data !== last_rx) begin failures++; $display("FAIL fe_data_kept: got %h want %h", rx_data, last_rx); end
        pulse_ack();
        checks++; if (rx_error !== 1'b0) begin failures++; $display("FAIL fe_ack_clear: got %b want 0", rx_error); end
        repeat (20) @(posedge clk);
    endtask

    task automatic test_glitch();
        logic [7:0] b;
        b = 8'($urandom);
        loopback = 1'b0;
        @(posedge clk); #1;
        rxd_drv = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        rxd_drv = 1'b1;
        repeat (1000) @(negedge clk);
        checks++; if (rx_avail !== 1'b0 || rx_error !== 1'b0) begin
            failures++; $display("FAIL glitch_reject: avail=%b error=%b want 0/0", rx_avail, rx_error);
        end
        drive_frame(frame_bits(b, 1'b1));
        @(negedge clk);
        checks++; if (rx_avail !== 1'b1 || rx_data !== b) begin
            failures++; $display("FAIL glitch_recover: avail=%b data=%h want 1/%h", rx_avail, rx_data, b);
        end
        last_rx = b;
        pulse_ack();
    endtask

    task automatic test_write_while_busy();
        logic [7:0] b1, b2;
        logic [9:0] early, late, exp;
        bit         found;
        int         busy_cycles;
        bit         quiet;
        b1 = 8'($urandom);
        b2 = ~b1;
        exp = frame_bits(b1, 1'b1);
        loopback = 1'b1;
        write_byte(b1);
        fork
            capture_tx_frame(early, late, found);
            count_busy(busy_cycles);
            begin
                repeat (1000) @(posedge clk);
                #1;
                tx_data = b2;
                tx_wr   = 1'b1;
                @(posedge clk); #1;
                tx_wr   = 1'b0;
            end
        join
        checks++; if (!found || early !== exp || late !== exp) begin
            failures++; $display("FAIL busy_write_frame: got %b/%b want %b", early, late, exp);
        end
        checks++; if (rx_avail !== 1'b1 || rx_data !== b1) begin
            failures++; $display("FAIL busy_write_rx: avail=%b data=%h want 1/%h", rx_avail, rx_data, b1);
        end
        last_rx = b1;
        pulse_ack();
        quiet = 1'b1;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (uart_txd !== 1'b1 || tx_busy !== 1'b0) quiet = 1'b0;
        end
        checks++; if (!quiet) begin failures++; $display("FAIL busy_write_dropped: line active after frame, want idle"); end
    endtask

    task automatic test_reset_midframe_burst();
        logic [7:0] q[$];
        bit         low_seen;
        int         received;
        loopback = 1'b1;
        write_byte(8'h67);
        repeat (500) @(negedge clk);
        low_seen = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (uart_txd === 1'b0) begin
                low_seen = 1'b1;
                break;
            end
        end
        checks++; if (!low_seen) begin failures++; $display("FAIL rst_mid_setup: txd never low mid-frame"); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (uart_txd !== 1'b1 || tx_busy !== 1'b0) begin
            failures++; $display("FAIL rst_mid_async: txd=%b busy=%b want 1/0", uart_txd, tx_busy);
        end
        checks++; if (rx_avail !== 1'b0 || rx_error !== 1'b0 || rx_data !== 8'h00) begin
            failures++; $display("FAIL rst_mid_rx: avail=%b error=%b data=%h want 0/0/00", rx_avail, rx_error, rx_data);
        end
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (10) @(posedge clk);

        q.push_back(8'h67);
        for (int i = 0; i < 8; i++) q.push_back(8'h00);
        received = 0;
        fork
            begin
                bit idle;
                for (int i = 0; i < 9; i++) begin
                    wait_idle(idle);
                    if (!idle) break;
                    write_byte(q[i]);
                end
            end
            begin
                int cycles;
                bit seen;
                for (int i = 0; i < 9; i++) begin
                    wait_avail(6000, cycles, seen);
                    if (!seen) break;
                    checks++; if (rx_data !== q[i] || rx_error !== 1'b0) begin
                        failures++; $display("FAIL burst_byte%0d: data=%h error=%b want %h/0", i, rx_data, rx_error, q[i]);
                    end
                    received++;
                    pulse_ack();
                end
            end
        join
        checks++; if (received != 9) begin failures++; $display("FAIL burst_count: got %0d bytes want 9", received); end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_tx_frame();
        test_loopback(8'h00);
        test_framing_error();
        test_glitch();
        test_write_while_busy();
        test_reset_midframe_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
